// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: bytes arrive over valid/ready and leave on `so` as
// start bit, 8 data bits, optional even parity bit and stop bit.
module serial_frame_tx #(
    parameter int unsigned BIT_CYCLES = 1,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       so,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam logic [7:0] LastCyc = 8'(BIT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] cyc_cnt_q, cyc_cnt_d;
    logic       so_q, so_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       bit_end;
    logic       cur_bit;

    assign bit_end = (cyc_cnt_q == LastCyc);
    assign cur_bit = MSB_FIRST ? shift_q[7] : shift_q[0];

    // Outputs are derived from next-state values so they are registered yet
    // change on the same edge as the state they describe.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;

        if (state_q != IDLE) begin
            cyc_cnt_d = bit_end ? 8'd0 : cyc_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d     = START;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    par_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                    par_d     = par_q ^ cur_bit;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Back-to-back frames skip the idle load cycle entirely.
                    if (hold_full_q) begin
                        state_d     = START;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        par_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load needs hold_full_q set and an accept needs it clear, so they never collide.
        if (din_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = din;
        end

        case (state_d)
            START:   so_d = 1'b0;
            DATA:    so_d = MSB_FIRST ? shift_d[7] : shift_d[0];
            PARITY:  so_d = par_d;
            default: so_d = 1'b1;
        endcase

        frame_done_d = (state_d == STOP) && (cyc_cnt_d == LastCyc);
        busy_d       = (state_d != IDLE) || hold_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            hold_full_q  <= 1'b0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            bit_cnt_q    <= 3'd0;
            cyc_cnt_q    <= 8'd0;
            so_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            bit_cnt_q    <= bit_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            so_q         <= so_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign din_ready  = !hold_full_q;
    assign so         = so_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: four configurations share one input stream, each
// checked every cycle against a waveform-queue model, plus directed sequences.
module tb_serial_frame_tx;

    localparam int NDUT = 4;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       expSo;
        logic       expReady;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    logic            clk;
    logic            resetN;
    logic [7:0]      din;
    logic            dinValid;
    logic [NDUT-1:0] dinReady;
    logic [NDUT-1:0] so;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] frameDone;

    int nVec;
    int nMis;
    bit checkOn;

    bit              hf [NDUT];
    logic [7:0]      hb [NDUT];
    bit              lineQ [NDUT][$];
    logic [NDUT-1:0] eSo;
    logic [NDUT-1:0] eBusy;
    logic [NDUT-1:0] eDone;
    logic [NDUT-1:0] eReady;

    serial_frame_tx #(.BIT_CYCLES(1), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dutA (
        .clk(clk), .reset_n(resetN), .din(din), .din_valid(dinValid),
        .din_ready(dinReady[0]), .so(so[0]), .busy(busy[0]), .frame_done(frameDone[0]));
    serial_frame_tx #(.BIT_CYCLES(1), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dutB (
        .clk(clk), .reset_n(resetN), .din(din), .din_valid(dinValid),
        .din_ready(dinReady[1]), .so(so[1]), .busy(busy[1]), .frame_done(frameDone[1]));
    serial_frame_tx #(.BIT_CYCLES(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dutC (
        .clk(clk), .reset_n(resetN), .din(din), .din_valid(dinValid),
        .din_ready(dinReady[2]), .so(so[2]), .busy(busy[2]), .frame_done(frameDone[2]));
    serial_frame_tx #(.BIT_CYCLES(3), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dutD (
        .clk(clk), .reset_n(resetN), .din(din), .din_valid(dinValid),
        .din_ready(dinReady[3]), .so(so[3]), .busy(busy[3]), .frame_done(frameDone[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bitCycles(input int d);
        case (d)
            0, 1:    return 1;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic bit msbFirst(input int d);
        return d <= 1;
    endfunction

    function automatic bit parityEn(input int d);
        return (d == 1) || (d == 3);
    endfunction

    // The model lays out a whole frame as a per-clock list of line levels.
    function automatic void pushFrame(input int d, input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(msbFirst(d) ? b[7-i] : b[i]);
        if (parityEn(d)) bits.push_back(^b);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < bitCycles(d); c++) lineQ[d].push_back(bits[k]);
        end
    endfunction

    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Reference model: an empty line queue means the line is free, so a held
    // byte becomes a frame on that edge; acceptance uses the pre-edge hold flag.
    always @(posedge clk or negedge resetN) begin
        bit accept;
        bit popped;
        if (!resetN) begin
            for (int d = 0; d < NDUT; d++) begin
                hf[d] = 1'b0;
                lineQ[d].delete();
                eSo[d] = 1'b1;
                eBusy[d] = 1'b0;
                eDone[d] = 1'b0;
                eReady[d] = 1'b1;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                accept = dinValid && !hf[d];
                if (lineQ[d].size() == 0 && hf[d]) begin
                    pushFrame(d, hb[d]);
                    hf[d] = 1'b0;
                end
                popped = (lineQ[d].size() != 0);
                eSo[d] = popped ? lineQ[d].pop_front() : 1'b1;
                if (accept) begin
                    hf[d] = 1'b1;
                    hb[d] = din;
                end
                eDone[d] = popped && (lineQ[d].size() == 0);
                eBusy[d] = popped || hf[d];
                eReady[d] = !hf[d];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (resetN && checkOn) begin
            for (int d = 0; d < NDUT; d++) begin
                checkOutput("modelSo", d, so[d], eSo[d]);
                checkOutput("modelReady", d, dinReady[d], eReady[d]);
                checkOutput("modelBusy", d, busy[d], eBusy[d]);
                checkOutput("modelDone", d, frameDone[d], eDone[d]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] b);
        dinValid = v;
        din = b;
        tick();
    endtask

    task automatic waitIdle;
        int n;
        dinValid = 1'b0;
        n = 0;
        while (busy != '0 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("idleWait", 0, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t       tbl [12];
        logic [7:0] a5;
        logic [7:0] po;
        int         n;

        nVec = 0;
        nMis = 0;
        checkOn = 1'b0;
        resetN = 1'b0;
        din = 8'h00;
        dinValid = 1'b0;

        a5 = 8'hA5;
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) tbl[2+k] = '{1'b0, 8'h00, a5[7-k], 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) tick();
        checkOutput("rstSo", 0, so, {NDUT{1'b1}});
        checkOutput("rstReady", 0, dinReady, {NDUT{1'b1}});
        checkOutput("rstBusy", 0, busy, 0);
        checkOutput("rstDone", 0, frameDone, 0);
        resetN = 1'b1;
        checkOn = 1'b1;
        tick();

        $display("[TB] A5 table on the 1-cycle MSB-first unit");
        po = 8'h00;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].data);
            checkOutput("tblSo", 0, so[0], tbl[i].expSo);
            checkOutput("tblReady", 0, dinReady[0], tbl[i].expReady);
            checkOutput("tblBusy", 0, busy[0], tbl[i].expBusy);
            checkOutput("tblDone", 0, frameDone[0], tbl[i].expDone);
            if (i >= 2 && i <= 9) po = {po[6:0], so[0]};
        end
        checkOutput("downstreamPO", 0, po, 8'hA5);
        waitIdle();

        $display("[TB] back-to-back 3C then C3");
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'hC3);
        dinValid = 1'b0;
        n = 0;
        while (!frameDone[0] && n < 50) begin
            checkOutput("readyLowWhileHeld", 0, dinReady[0], 0);
            tick();
            n++;
        end
        checkOutput("firstDoneSeen", 0, frameDone[0], 1);
        checkOutput("firstStopHigh", 0, so[0], 1);
        tick();
        checkOutput("b2bStartLow", 0, so[0], 0);
        checkOutput("b2bBusy", 0, busy[0], 1);
        checkOutput("b2bReadyBack", 0, dinReady[0], 1);
        waitIdle();

        $display("[TB] parity unit: 07 then 03");
        for (int p = 0; p < 2; p++) begin
            applyStimulus(1'b1, (p == 0) ? 8'h07 : 8'h03);
            applyStimulus(1'b0, 8'h00);
            repeat (8) tick();
            tick();
            checkOutput((p == 0) ? "parity07" : "parity03", 1, so[1], (p == 0) ? 1 : 0);
            checkOutput("parityNoDone", 1, frameDone[1], 0);
            tick();
            checkOutput("parityStopDone", 1, frameDone[1], 1);
            checkOutput("parityStopHigh", 1, so[1], 1);
            waitIdle();
        end

        $display("[TB] 4-cycle LSB-first unit, busy span for 01");
        applyStimulus(1'b1, 8'h01);
        dinValid = 1'b0;
        n = 0;
        while (busy[2] && n < 200) begin
            n++;
            tick();
        end
        checkOutput("busySpan41", 2, n, 41);
        waitIdle();

        $display("[TB] reset mid-frame with a byte held");
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'hAA);
        dinValid = 1'b0;
        repeat (2) tick();
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midRstSo", 0, so, {NDUT{1'b1}});
        checkOutput("midRstReady", 0, dinReady, {NDUT{1'b1}});
        checkOutput("midRstBusy", 0, busy, 0);
        checkOutput("midRstDone", 0, frameDone, 0);
        repeat (3) @(posedge clk);
        #3;
        resetN = 1'b1;
        repeat (15) tick();
        checkOutput("postRstIdle", 0, busy, 0);

        $display("[TB] random traffic");
        for (int r = 0; r < 3000; r++) begin
            applyStimulus($urandom_range(0, 99) < 40, 8'($urandom));
        end
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
